data_sync_hs: RTL

DATA_SYNC_HS -- requirements
Module: data_sync_hs

---
 rtl/data_sync_hs.sv | 85 ++++++++
 1 files changed

// File: rtl/data_sync_hs.sv
// Multi-channel request/acknowledge data synchroniser. Each channel brings an
// asynchronous request through a flop chain and captures its bus on the detected event.
module data_sync_hs_ch #(
  parameter int NUM_STAGE   = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] din,
  input  logic                 req,
  input  logic                 ready,
  input  logic                 ovr_clr,
  output logic [BUS_WIDTH-1:0] dout,
  output logic                 pulse,
  output logic                 valid,
  output logic                 ack,
  output logic                 ovr
);
  logic [NUM_STAGE-1:0] chain;
  logic                 sreq;
  logic                 evt;

  assign sreq = chain[NUM_STAGE-1];
  // ack is the delay flop, so the edge detector compares against what the source sees
  assign evt  = (TOGGLE_MODE != 0) ? (sreq ^ ack) : (sreq & ~ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      ack   <= 1'b0;
      pulse <= 1'b0;
      dout  <= '0;
      valid <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      chain <= {chain[NUM_STAGE-2:0], req};
      ack   <= sreq;
      pulse <= evt;
      if (evt) dout <= din;
      valid <= evt | (valid & ~ready);
      // a fresh overwrite beats a simultaneous clear
      ovr   <= (ovr & ~ovr_clr) | (evt & valid & ~ready);
    end
  end
endmodule

module data_sync_hs #(
  parameter int NUM_STAGE   = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic                        ovr_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           sync_ack,
  output logic [NUM_CH-1:0]           overrun
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_sync_hs_ch #(
      .NUM_STAGE  (NUM_STAGE),
      .BUS_WIDTH  (BUS_WIDTH),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .req    (bus_enable[c]),
      .ready  (sync_ready[c]),
      .ovr_clr(ovr_clr),
      .dout   (sync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .pulse  (enable_pulse[c]),
      .valid  (sync_valid[c]),
      .ack    (sync_ack[c]),
      .ovr    (overrun[c])
    );
  end
endmodule
